shuffle_commutator: RTL and testbench
=====================================

SHUFFLE_COMMUTATOR -- requirements
Module: shuffle_commutator

Interface
REQ-001 Parameter WIDTH, default 28: data word width; matches the 28-bit butterfly datapath.
REQ-002 Parameter DELAY, default 4: pairing distance D in beats; power of two, 1 to 64.
REQ-003 Clock and reset SHALL be: reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  high means x_in/y_in carry one accepted pair (beat) this cycle.
REQ-007 x_in  input  WIDTH  upper element a of input pair (butterfly x_out stream).
REQ-008 y_in  input  WIDTH  lower element b of input pair (butterfly y_out stream).
REQ-009 out_valid  output  1  high means x_out/y_out carry one output pair.
REQ-010 x_out  output  WIDTH  upper element of re-paired output (feeds next butterfly x_in).
REQ-011 y_out  output  WIDTH  lower element of re-paired output (feeds next butterfly y_in).
REQ-012 out_first  output  1  high with out_valid on output index 0 of each 2D-beat block.

Function
REQ-013 Input beats SHALL be numbered n = 0,1,2,... in acceptance order from reset; block k = beats 2Dk..2Dk+2D-1, pairs (a_i, b_i) with i = 0..2D-1 within the block.
REQ-014 Output block k SHALL be: indices j = 0..D-1 -> (a_j, a_{j+D}); indices j = D..2D-1 -> (b_{j-D}, b_j).
REQ-015 Output index m (global, m = 2Dk + j) SHALL be produced when input beat n = m + D is accepted, registered: x_out/y_out/out_valid valid the cycle after that acceptance.
REQ-016 Accepted beats 0..D-1 after reset SHALL produce no output (priming); out_valid stays low for them.
REQ-017 Cycle with in_valid low SHALL freeze all buffers, beat counter and priming state; out_valid low the following cycle; x_out/y_out hold last value.
REQ-018 With continuous in_valid, output SHALL be one pair per cycle with no gaps after priming; latency D+1 cycles from beat n to output m = n - D.
REQ-019 Beat counter SHALL count modulo 2D and wrap silently; block boundaries follow it with no reset of buffers between blocks.
REQ-020 Trailing D outputs of the final block SHALL be emitted only as further beats are accepted; drain requires D padding beats (values don't care).
REQ-021 out_first SHALL be high exactly when out_valid is high and output index j = 0.
REQ-022 Data SHALL pass unmodified (no arithmetic); storage SHALL be at most 2D words per input lane plus output registers.
REQ-023 DELAY = 1 SHALL work: outputs alternate (a_0,a_1),(b_0,b_1) per 2-beat block.

Reset
REQ-024 During rst: out_valid = 0, out_first = 0, x_out = 0, y_out = 0, beat counter = 0, priming cleared; buffer contents don't care.
REQ-025 rst asserted mid-stream SHALL discard all buffered beats; beat accepted in the first cycle after rst deasserts is n = 0.
REQ-026 rst SHALL take priority over a simultaneous in_valid; that beat is not accepted.

Verification
REQ-027 D=2, continuous beats cycles 0..7 a = 10,11,12,13,30,31,32,33, b = 20,21,22,23,40,41,42,43 -> out_valid from cycle 3; outputs (10,12),(11,13),(20,22),(21,23),(30,32),(31,33) at cycles 3..8, out_first high cycles 3 and 7.
REQ-028 Same stimulus with in_valid low in cycles 2 and 5 (beats shifted) -> identical output sequence, out_valid low exactly one cycle after each bubble, no duplicated/lost pair.
REQ-029 D=4, 16 continuous beats a = n, b = 100+n -> outputs (0,4),(1,5),(2,6),(3,7),(100,104),(101,105),(102,106),(103,107),(8,12),... with latency 5 cycles.
REQ-030 D=1, beats (1,2),(3,4),(5,6) -> outputs (1,3) cycle 2, (2,4) cycle 3; out_first on cycle 2.
REQ-031 rst pulsed after beat 5 of a D=2 stream, then beats resume with a = 50.. -> no stale pair appears; first output (50,52) one cycle after the third post-reset beat.
REQ-032 Random 10k-beat stream with random in_valid gaps, D in {1,2,8,64} -> scoreboard model of REQ-014/015 matches every output pair.

Source files
------------

// File: rtl/shuffle_commutator_if.sv
// Pair-stream bundle between two butterfly stages: one input pair and one
// re-paired output pair per cycle, each with its own valid.
interface shuffle_commutator_if #(
  parameter int WIDTH = 28
);
  logic             in_valid;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             out_valid;
  logic             out_first;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;

  // master: upstream producer / consumer side (drives the input pair)
  modport master (
    output in_valid, x_in, y_in,
    input  out_valid, out_first, x_out, y_out
  );

  // slave: the commutator itself
  modport slave (
    input  in_valid, x_in, y_in,
    output out_valid, out_first, x_out, y_out
  );
endinterface

// File: rtl/shuffle_commutator.sv
// Shuffle commutator: re-pairs a butterfly output stream at distance DELAY.
// Each 2*DELAY-beat block yields (a_j, a_j+D) for j < D, then (b_j-D, b_j).
// Both lanes are kept in a 2*DELAY-deep ring indexed by the beat counter, so
// an element from the previous block is still readable in the slot about to
// be overwritten by the current beat.
//
// state   | meaning
// S_PRIME | first block still filling; beats with counter < D emit nothing
// S_RUN   | a previous block exists; every accepted beat emits one pair
module shuffle_commutator #(
  parameter int WIDTH = 28,
  parameter int DELAY = 4
) (
  input  logic                clk,
  input  logic                rst,
  shuffle_commutator_if.slave bus
);

  localparam int N2 = 2 * DELAY;
  localparam int CW = $clog2(N2);
  localparam logic [CW-1:0] D_C    = CW'(DELAY);
  localparam logic [CW-1:0] LAST_C = CW'(N2 - 1);

  typedef enum logic {S_PRIME, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [WIDTH-1:0] a_mem_q [N2];
  logic [WIDTH-1:0] b_mem_q [N2];

  // Next-state and output selection for the beat presented this cycle.
  // Upper half of a block pairs the current a with the a from D beats ago;
  // lower half drains the b lane of the previous block.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    if (bus.in_valid) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q >= D_C) begin
        out_valid_d = 1'b1;
        out_first_d = (cnt_q == D_C);
        x_d         = a_mem_q[cnt_q - D_C];
        y_d         = bus.x_in;
      end else if (state_q == S_RUN) begin
        out_valid_d = 1'b1;
        x_d         = b_mem_q[cnt_q];
        y_d         = b_mem_q[cnt_q + D_C];
      end
      if (cnt_q == LAST_C) begin
        state_d = S_RUN;
      end
    end
  end

  // Control and output registers; synchronous reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PRIME;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // Ring buffer write of the accepted beat; contents are not reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !rst) begin
      a_mem_q[cnt_q] <= bus.x_in;
      b_mem_q[cnt_q] <= bus.y_in;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;

endmodule

// File: tb/tb_shuffle_commutator.sv
// Bench for shuffle_commutator: five instances (DELAY 1,2,4,8,64) share one
// input stream; each is compared every cycle against a beat-history model.
module tb_shuffle_commutator;

  localparam int W  = 28;
  localparam int NI = 5;
  localparam int H  = 16384;

  logic clk;
  logic rst;
  logic in_valid;
  logic [W-1:0] x_in, y_in;

  logic [NI-1:0] ov, of;
  logic [W-1:0]  ox [NI];
  logic [W-1:0]  oy [NI];

  logic [NI-1:0] exp_v, exp_f;
  logic [W-1:0]  exp_x [NI];
  logic [W-1:0]  exp_y [NI];

  logic [W-1:0] ah [NI][H];
  logic [W-1:0] bh [NI][H];
  int nb [NI];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g < 4) ? (1 << g) : 64;
    shuffle_commutator_if #(.WIDTH(W)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.x_in     = x_in;
    assign bus.y_in     = y_in;
    shuffle_commutator #(.WIDTH(W), .DELAY(DG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign ov[g] = bus.out_valid;
    assign of[g] = bus.out_first;
    assign ox[g] = bus.x_out;
    assign oy[g] = bus.y_out;
  end

  function automatic int dof(input int g);
    return (g < 4) ? (1 << g) : 64;
  endfunction

  // One cycle: drive at negedge, advance the model, land 1 after posedge.
  // The model works from the block rule directly: output m = n - D of block
  // k = m / 2D at index j pairs a_j with a_j+D or b_j-D with b_j.
  task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst = r; in_valid = v; x_in = a; y_in = b;
    for (int g = 0; g < NI; g++) begin
      int d, n, m, j, base;
      d = dof(g);
      exp_v[g] = 1'b0;
      exp_f[g] = 1'b0;
      if (r) begin
        nb[g] = 0; exp_x[g] = '0; exp_y[g] = '0;
      end else if (v) begin
        n = nb[g];
        ah[g][n % H] = a;
        bh[g][n % H] = b;
        if (n >= d) begin
          m = n - d; j = m % (2 * d); base = m - j;
          if (j < d) begin
            exp_x[g] = ah[g][(base + j) % H];
            exp_y[g] = ah[g][(base + j + d) % H];
          end else begin
            exp_x[g] = bh[g][(base + j - d) % H];
            exp_y[g] = bh[g][(base + j) % H];
          end
          exp_v[g] = 1'b1;
          exp_f[g] = (j == 0);
        end
        nb[g] = n + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, W'($urandom), W'($urandom));
      for (int g = 0; g < NI; g++) begin
        n_checks++;
        if ({ov[g], of[g], ox[g], oy[g]} !== {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}})
          $display("FAIL reset D=%0d: got v=%0b f=%0b x=%0d y=%0d want all zero", dof(g), ov[g], of[g], ox[g], oy[g]);
        else n_pass++;
      end
    end
  endtask

  // Shared by the two D=2 directed scenarios; the bubble pattern differs.
  task automatic test_d2_stream(input string name, input logic [9:0] vpat);
    logic [W-1:0] got [$];
    int exp_list [12] = '{10,12,11,13,20,22,21,23,30,32,31,33};
    int a_list [8] = '{10,11,12,13,30,31,32,33};
    int bi;
    step(1'b1, 1'b0, '0, '0);
    bi = 0;
    for (int c = 0; c < 10; c++) begin
      if (vpat[c] && bi < 8) begin
        step(1'b0, 1'b1, W'(a_list[bi]), W'(a_list[bi] + 10));
        bi++;
      end else step(1'b0, 1'b0, W'($urandom), W'($urandom));
      for (int g = 0; g < NI; g++) begin
        n_checks++;
        if ({ov[g], of[g], ox[g], oy[g]} !== {exp_v[g], exp_f[g], exp_x[g], exp_y[g]})
          $display("FAIL %s D=%0d c=%0d: got v=%0b f=%0b x=%0d y=%0d want v=%0b f=%0b x=%0d y=%0d",
                   name, dof(g), c, ov[g], of[g], ox[g], oy[g], exp_v[g], exp_f[g], exp_x[g], exp_y[g]);
        else n_pass++;
      end
      if (ov[1]) begin got.push_back(ox[1]); got.push_back(oy[1]); end
    end
    n_checks++;
    if (got.size() != 12) $display("FAIL %s list size: got %0d want 12", name, got.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== W'(exp_list[i])) $display("FAIL %s list[%0d]: got %0d want %0d", name, i, got[i], exp_list[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_d4_ramp();
    logic [W-1:0] got [$];
    int exp_list [18] = '{0,4,1,5,2,6,3,7,100,104,101,105,102,106,103,107,8,12};
    step(1'b1, 1'b0, '0, '0);
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, W'(n), W'(100 + n));
      for (int g = 0; g < NI; g++) begin
        n_checks++;
        if ({ov[g], of[g], ox[g], oy[g]} !== {exp_v[g], exp_f[g], exp_x[g], exp_y[g]})
          $display("FAIL d4_ramp D=%0d n=%0d: got v=%0b f=%0b x=%0d y=%0d want v=%0b f=%0b x=%0d y=%0d",
                   dof(g), n, ov[g], of[g], ox[g], oy[g], exp_v[g], exp_f[g], exp_x[g], exp_y[g]);
        else n_pass++;
      end
      if (ov[2]) begin got.push_back(ox[2]); got.push_back(oy[2]); end
      if (n == 3) begin
        n_checks++;
        if (ov[2] !== 1'b0) $display("FAIL d4_ramp latency: out_valid got %0b want 0 before beat 4", ov[2]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL d4_ramp list[%0d]: got none want %0d", i, exp_list[i]);
      else if (got[i] !== W'(exp_list[i])) $display("FAIL d4_ramp list[%0d]: got %0d want %0d", i, got[i], exp_list[i]);
      else n_pass++;
    end
  endtask

  task automatic test_d1();
    logic [W-1:0] got [$];
    int exp_list [4] = '{1,3,2,4};
    logic [2:0] fl;
    step(1'b1, 1'b0, '0, '0);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, W'(2 * n + 1), W'(2 * n + 2));
      fl[n] = of[0];
      if (ov[0]) begin got.push_back(ox[0]); got.push_back(oy[0]); end
    end
    n_checks++;
    if (fl !== 3'b010) $display("FAIL d1 out_first: got %b want 010", fl);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL d1 list[%0d]: got none want %0d", i, exp_list[i]);
      else if (got[i] !== W'(exp_list[i])) $display("FAIL d1 list[%0d]: got %0d want %0d", i, got[i], exp_list[i]);
      else n_pass++;
    end
  endtask

  task automatic test_midstream_reset();
    int first_at;
    logic [W-1:0] got [$];
    int exp_list [8] = '{50,52,51,53,70,72,71,73};
    step(1'b1, 1'b0, '0, '0);
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, W'($urandom), W'($urandom));
    step(1'b1, 1'b1, W'($urandom), W'($urandom));
    first_at = -1;
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b1, W'(50 + n), W'(70 + n));
      for (int g = 0; g < NI; g++) begin
        n_checks++;
        if ({ov[g], of[g], ox[g], oy[g]} !== {exp_v[g], exp_f[g], exp_x[g], exp_y[g]})
          $display("FAIL mid_reset D=%0d n=%0d: got v=%0b f=%0b x=%0d y=%0d want v=%0b f=%0b x=%0d y=%0d",
                   dof(g), n, ov[g], of[g], ox[g], oy[g], exp_v[g], exp_f[g], exp_x[g], exp_y[g]);
        else n_pass++;
      end
      if (ov[1]) begin
        if (first_at < 0) first_at = n;
        got.push_back(ox[1]); got.push_back(oy[1]);
      end
    end
    n_checks++;
    if (first_at != 2) $display("FAIL mid_reset first output: got beat %0d want beat 2", first_at);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL mid_reset list[%0d]: got none want %0d", i, exp_list[i]);
      else if (got[i] !== W'(exp_list[i])) $display("FAIL mid_reset list[%0d]: got %0d want %0d", i, got[i], exp_list[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int bad;
    step(1'b1, 1'b0, '0, '0);
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      step(1'b0, ($urandom % 4) != 0, W'($urandom), W'($urandom));
      for (int g = 0; g < NI; g++) begin
        n_checks++;
        if ({ov[g], of[g], ox[g], oy[g]} !== {exp_v[g], exp_f[g], exp_x[g], exp_y[g]}) begin
          if (bad < 20)
            $display("FAIL random D=%0d c=%0d: got v=%0b f=%0b x=%0h y=%0h want v=%0b f=%0b x=%0h y=%0h",
                     dof(g), c, ov[g], of[g], ox[g], oy[g], exp_v[g], exp_f[g], exp_x[g], exp_y[g]);
          bad++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    for (int g = 0; g < NI; g++) nb[g] = 0;
    test_reset();
    test_d2_stream("d2_continuous", 10'b1111111111);
    test_d2_stream("d2_bubbles",    10'b1111011011);
    test_d4_ramp();
    test_d1();
    test_midstream_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
